// File: rtl/c64_keyboard_matrix_if.sv
// Byte-stream handshake between the PS/2 receiver (master) and the keyboard
// matrix block (slave). A byte transfers on a clock where kb_valid & kb_ready.
interface c64_keyboard_matrix_if;
  logic [7:0] kb_data;
  logic       kb_valid;
  logic       kb_ready;

  modport master (output kb_data, output kb_valid, input kb_ready);
  modport slave  (input kb_data, input kb_valid, output kb_ready);
endinterface

// File: rtl/c64_keyboard_matrix.sv
// PS/2 scancode stream to C64 8x8 keyboard matrix, with a passive registered
// CIA1 scan model (PB-read direction plus optional single-hop PA ghosting).
module c64_keyboard_matrix #(
  parameter bit EXT_IN_ADDR = 1'b1,
  parameter bit GHOST       = 1'b1
) (
  input  logic                         clk,
  input  logic                         res,
  c64_keyboard_matrix_if.slave         kb,
  output logic [8:0]                   rom_addr,
  output logic                         rom_rd,
  input  logic [7:0]                   rom_data,
  input  logic [7:0]                   pa_drv,
  input  logic [7:0]                   pa_oe,
  input  logic [7:0]                   pb_drv,
  input  logic [7:0]                   pb_oe,
  output logic [7:0]                   pa_in,
  output logic [7:0]                   pb_in,
  output logic                         restore_n,
  output logic [63:0]                  key_matrix
);

  typedef enum logic [1:0] {S_IDLE, S_LOOK, S_APPLY} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_matrix;
  logic        r_ext;
  logic        r_brk;
  logic        r_restore_n;
  logic [8:0]  r_rom_addr;
  logic        r_rom_rd;
  logic [7:0]  r_pa_in;
  logic [7:0]  r_pb_in;
  logic        w_accept;
  logic        w_is_key;
  logic        w_self_test;
  logic [7:0]  w_pa_eff;
  logic [7:0]  w_pb_eff;
  logic [7:0]  w_pa_scan;
  logic [7:0]  w_pb_scan;
  logic [7:0][7:0] w_m;

  assign w_self_test = (kb.kb_data == 8'hAA) || (kb.kb_data == 8'hFC);
  assign w_is_key    = (kb.kb_data != 8'hE0) && (kb.kb_data != 8'hF0) && !w_self_test;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    kb.kb_ready = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        kb.kb_ready = 1'b1;
        w_accept    = kb.kb_valid;
        if (kb.kb_valid && w_is_key) w_state_nxt = S_LOOK;
      end
      S_LOOK:  w_state_nxt = S_APPLY;
      S_APPLY: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the 64-bit matrix is plain flops, not a RAM, so it is cleared by
  // the async reset along with the flags.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_matrix    <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_restore_n <= 1'b1;
      r_rom_addr  <= '0;
      r_rom_rd    <= 1'b0;
    end else begin
      r_rom_rd <= 1'b0;
      if (w_accept) begin
        if (kb.kb_data == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (kb.kb_data == 8'hF0) begin
          r_brk <= 1'b1;
        end else if (w_self_test) begin
          r_matrix    <= '0;
          r_restore_n <= 1'b1;
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
        end else begin
          r_rom_addr <= {r_ext & EXT_IN_ADDR, kb.kb_data};
          r_rom_rd   <= 1'b1;
        end
      end
      if (r_state == S_APPLY) begin
        // ROM word: {valid, restore, row[2:0], col[2:0]}
        if (rom_data[7]) begin
          if (rom_data[6]) r_restore_n <= r_brk;
          else             r_matrix[rom_data[5:0]] <= ~r_brk;
        end
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // Undriven CIA pins float high; a pressed key pulls the crossing line low.
  always_comb begin
    w_m       = r_matrix;
    w_pa_eff  = pa_drv | ~pa_oe;
    w_pb_eff  = pb_drv | ~pb_oe;
    w_pb_scan = '1;
    w_pa_scan = '1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (w_m[r[2:0]][c[2:0]]) begin
          w_pb_scan[r[2:0]] = w_pb_scan[r[2:0]] & w_pa_eff[c[2:0]];
          if (GHOST) w_pa_scan[c[2:0]] = w_pa_scan[c[2:0]] & w_pb_eff[r[2:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pa_in <= 8'hFF;
      r_pb_in <= 8'hFF;
    end else begin
      r_pa_in <= w_pa_scan;
      r_pb_in <= w_pb_scan;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign rom_rd     = r_rom_rd;
  assign pa_in      = r_pa_in;
  assign pb_in      = r_pb_in;
  assign restore_n  = r_restore_n;
  assign key_matrix = r_matrix;

endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// Scoreboard bench: stimulus queues expected values, negedge monitors compare.
// Instance A uses default parameters; instance B has GHOST=0, EXT_IN_ADDR=0.
module tb_c64_keyboard_matrix;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [7:0]  kb_data = 8'h00;
  logic        kb_valid = 1'b0;
  logic [7:0]  pa_drv = 8'h00, pa_oe = 8'hFF, pb_drv = 8'hFF, pb_oe = 8'h00;

  logic [8:0]  rom_addr_a, rom_addr_b;
  logic        rom_rd_a, rom_rd_b;
  logic [7:0]  rom_data_a = 8'h00, rom_data_b = 8'h00;
  logic [7:0]  pa_in_a, pb_in_a, pa_in_b, pb_in_b;
  logic        restore_n_a, restore_n_b;
  logic [63:0] key_matrix_a, key_matrix_b;

  int n_checks = 0;
  int n_errors = 0;
  logic tb_ext = 1'b0;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t       chk_q[$];
  logic [8:0] rom_q_a[$];
  logic [8:0] rom_q_b[$];

  always #5 clk = ~clk;

  c64_keyboard_matrix_if kb_a ();
  c64_keyboard_matrix_if kb_b ();
  assign kb_a.kb_data  = kb_data;
  assign kb_a.kb_valid = kb_valid;
  assign kb_b.kb_data  = kb_data;
  assign kb_b.kb_valid = kb_valid;

  c64_keyboard_matrix dut_a (
    .clk(clk), .res(res), .kb(kb_a.slave),
    .rom_addr(rom_addr_a), .rom_rd(rom_rd_a), .rom_data(rom_data_a),
    .pa_drv(pa_drv), .pa_oe(pa_oe), .pb_drv(pb_drv), .pb_oe(pb_oe),
    .pa_in(pa_in_a), .pb_in(pb_in_a), .restore_n(restore_n_a),
    .key_matrix(key_matrix_a)
  );

  c64_keyboard_matrix #(.EXT_IN_ADDR(1'b0), .GHOST(1'b0)) dut_b (
    .clk(clk), .res(res), .kb(kb_b.slave),
    .rom_addr(rom_addr_b), .rom_rd(rom_rd_b), .rom_data(rom_data_b),
    .pa_drv(pa_drv), .pa_oe(pa_oe), .pb_drv(pb_drv), .pb_oe(pb_oe),
    .pa_in(pa_in_b), .pb_in(pb_in_b), .restore_n(restore_n_b),
    .key_matrix(key_matrix_b)
  );

  // Lookup ROM: 1C -> row1 col2, 1B -> row1 col5, E0 1E -> RESTORE
  function automatic logic [7:0] rom_lookup(input logic [8:0] a);
    case (a)
      9'h01C:  return 8'h8A;
      9'h01B:  return 8'h8D;
      9'h11E:  return 8'hC0;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rom_rd_a) rom_data_a <= rom_lookup(rom_addr_a);
    if (rom_rd_b) rom_data_b <= rom_lookup(rom_addr_b);
  end

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      0:       return {56'd0, pb_in_a};
      1:       return {56'd0, pa_in_a};
      2:       return {56'd0, pa_in_b};
      3:       return {63'd0, restore_n_a};
      4:       return {63'd0, kb_a.kb_ready};
      5:       return key_matrix_a;
      6:       return {55'd0, rom_addr_a};
      7:       return {63'd0, rom_rd_a};
      8:       return {56'd0, pb_in_b};
      default: return key_matrix_b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitors
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      check(c.name, actual(c.sel), c.exp);
    end
    if (rom_rd_a === 1'b1) begin
      if (rom_q_a.size() == 0) check("rom_rd_a_unexpected", 64'd1, 64'd0);
      else check("rom_addr_a", {55'd0, rom_addr_a}, {55'd0, rom_q_a.pop_front()});
    end
    if (rom_rd_b === 1'b1) begin
      if (rom_q_b.size() == 0) check("rom_rd_b_unexpected", 64'd1, 64'd0);
      else check("rom_addr_b", {55'd0, rom_addr_b}, {55'd0, rom_q_b.pop_front()});
    end
  end

  task automatic expect_now(input string name, input int sel, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the accepting edge; waited = refused cycles
  task automatic send(input logic [7:0] b, output int waited);
    kb_data  = b;
    kb_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (kb_a.kb_ready === 1'b1) break;
      waited++;
      if (waited > 20) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    if (b != 8'hE0 && b != 8'hF0 && b != 8'hAA && b != 8'hFC) begin
      rom_q_a.push_back({tb_ext, b});
      rom_q_b.push_back({1'b0, b});
    end
    tb_ext = (b == 8'hE0) ? 1'b1 : ((b == 8'hF0) ? tb_ext : 1'b0);
    @(posedge clk);
    #1;
    kb_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
    int w;
    if (n > 2) send(b0, w);
    if (n > 1) send(n > 2 ? b1 : b0, w);
    send(n > 2 ? b2 : (n > 1 ? b1 : b0), w);
  endtask

  initial begin
    int w;
    tick(3);
    res = 1'b0;
    expect_now("reset_pb_in", 0, 64'hFF);
    expect_now("reset_pa_in", 1, 64'hFF);
    expect_now("reset_restore_n", 3, 64'h1);
    expect_now("reset_kb_ready", 4, 64'h1);
    expect_now("reset_key_matrix", 5, 64'h0);
    expect_now("reset_rom_addr", 6, 64'h0);
    expect_now("reset_rom_rd", 7, 64'h0);
    expect_now("reset_pa_in_b", 2, 64'hFF);
    tick(1);

    // Press 1C with column 2 driven low
    pa_drv = 8'hFB;
    send(8'h1C, w);
    tick(2);
    expect_now("press_matrix", 5, 64'h400);
    expect_now("scan_pre_update", 0, 64'hFF);
    tick(1);
    expect_now("press_pb_in", 0, 64'hFD);
    expect_now("press_pb_in_b", 8, 64'hFD);

    pb_drv = 8'hFD;
    pb_oe  = 8'hFF;
    tick(1);
    expect_now("ghost_pa_in", 1, 64'hFB);
    expect_now("no_ghost_pa_in_b", 2, 64'hFF);

    pa_oe = 8'h00;
    tick(1);
    expect_now("pa_floating_pb_in", 0, 64'hFF);
    pa_oe  = 8'hFF;
    pb_drv = 8'hFF;
    pb_oe  = 8'h00;

    send_seq(8'hF0, 8'h1C, 8'h00, 2);
    tick(3);
    expect_now("release_matrix", 5, 64'h0);
    expect_now("release_pb_in", 0, 64'hFF);

    // RESTORE via extended code, both prefix orders
    send_seq(8'hE0, 8'h1E, 8'h00, 2);
    tick(2);
    expect_now("restore_press", 3, 64'h0);
    expect_now("restore_b_alias_ignored", 9, 64'h0);
    send_seq(8'hE0, 8'hF0, 8'h1E, 3);
    tick(2);
    expect_now("restore_release_e0f0", 3, 64'h1);
    send_seq(8'hE0, 8'h1E, 8'h00, 2);
    tick(2);
    expect_now("restore_press_again", 3, 64'h0);
    send_seq(8'hF0, 8'hE0, 8'h1E, 3);
    tick(2);
    expect_now("restore_release_f0e0", 3, 64'h1);

    // Two keys plus RESTORE, then keyboard self-test clears everything
    send(8'h1C, w);
    send(8'h1B, w);
    send_seq(8'hE0, 8'h1E, 8'h00, 2);
    tick(3);
    expect_now("two_keys_matrix", 5, 64'h2400);
    expect_now("two_keys_pb_in", 0, 64'hFD);
    expect_now("two_keys_restore", 3, 64'h0);
    send(8'hAA, w);
    expect_now("selftest_matrix", 5, 64'h0);
    expect_now("selftest_restore", 3, 64'h1);
    tick(1);
    expect_now("selftest_pb_in", 0, 64'hFF);

    // Back-to-back key bytes: second one held off until IDLE
    send(8'h1C, w);
    send(8'h1C, w);
    check("hold_wait_cycles", w, 2);
    tick(2);
    expect_now("hold_matrix", 5, 64'h400);
    send_seq(8'hF0, 8'h1C, 8'h00, 2);
    tick(3);
    expect_now("hold_release", 5, 64'h0);

    // Reset during LOOK discards the lookup
    send(8'h1B, w);
    tick(2);
    expect_now("prereset_matrix", 5, 64'h2000);
    send(8'h1C, w);
    @(negedge clk);
    #1;
    res = 1'b1;
    tick(1);
    expect_now("midreset_kb_ready", 4, 64'h1);
    expect_now("midreset_matrix", 5, 64'h0);
    expect_now("midreset_rom_rd", 7, 64'h0);
    tick(1);
    res = 1'b0;
    tick(4);
    expect_now("postreset_matrix", 5, 64'h0);
    expect_now("postreset_pb_in", 0, 64'hFF);
    tick(1);

    check("rom_q_a_drained", rom_q_a.size(), 0);
    check("rom_q_b_drained", rom_q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
